// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS control path and datapath.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_HOLD, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
    S_MEM_WR, S_WB_R, S_WB_MEM, S_BRANCH, S_JUMP, S_ILLEGAL
  } state_e;

  // Which ALU operation a state asks for; the decoder resolves it to alu_ctrl.
  typedef enum logic [1:0] {
    ALU_CLS_NONE, ALU_CLS_ADD, ALU_CLS_SUB, ALU_CLS_FUNCT
  } alu_class_e;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_ADD = 4'b0010;
  localparam logic [3:0] ALU_SUB = 4'b0110;
  localparam logic [3:0] ALU_SLT = 4'b0111;

  localparam logic [1:0] PC_SRC_INC    = 2'd0;
  localparam logic [1:0] PC_SRC_BRANCH = 2'd1;
  localparam logic [1:0] PC_SRC_JUMP   = 2'd2;

  localparam logic [1:0] ALU_B_RT  = 2'd0;
  localparam logic [1:0] ALU_B_ONE = 2'd1;
  localparam logic [1:0] ALU_B_IMM = 2'd2;

  // All controller outputs, so one default assignment zeroes everything.
  typedef struct packed {
    logic       pc_en;
    logic [1:0] pc_src;
    logic       branch;
    logic       ir_write;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_ctrl;
    logic       instr_done;
    logic       illegal;
  } ctrl_out_t;

endpackage

// File: rtl/mips_multicycle_ctrl_if.sv
// Control/status bundle between the controller (master) and datapath (slave).
interface mips_multicycle_ctrl_if;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero_flag;
  logic       mem_ready;
  logic       pc_en;
  logic [1:0] pc_src;
  logic       branch;
  logic       ir_write;
  logic       iord;
  logic       mem_rd;
  logic       mem_wr;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic [3:0] alu_ctrl;
  logic       instr_done;
  logic       illegal;

  modport master (
    input  opcode, funct, zero_flag, mem_ready,
    output pc_en, pc_src, branch, ir_write, iord, mem_rd, mem_wr,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_ctrl, instr_done, illegal
  );

  modport slave (
    output opcode, funct, zero_flag, mem_ready,
    input  pc_en, pc_src, branch, ir_write, iord, mem_rd, mem_wr,
           reg_write, reg_dst, mem_to_reg, alu_src_a, alu_src_b,
           alu_ctrl, instr_done, illegal
  );
endinterface

// File: rtl/mips_alu_decoder.sv
// Maps the requesting state class and funct field to an ALU operation code.
module mips_alu_decoder
  import mips_ctrl_pkg::*;
(
  input  alu_class_e alu_class_i,
  input  logic [5:0] funct_i,
  output logic [3:0] alu_ctrl_o,
  output logic       funct_ok_o
);

  // Fixed ops for address/PC arithmetic, funct lookup for R-type execute.
  always_comb begin
    // NOTE: every output gets a default first so no path infers a latch.
    alu_ctrl_o = ALU_AND;
    funct_ok_o = 1'b0;
    case (alu_class_i)
      ALU_CLS_ADD: begin alu_ctrl_o = ALU_ADD; funct_ok_o = 1'b1; end
      ALU_CLS_SUB: begin alu_ctrl_o = ALU_SUB; funct_ok_o = 1'b1; end
      ALU_CLS_FUNCT: begin
        funct_ok_o = 1'b1;
        case (funct_i)
          FN_ADD:  alu_ctrl_o = ALU_ADD;
          FN_SUB:  alu_ctrl_o = ALU_SUB;
          FN_AND:  alu_ctrl_o = ALU_AND;
          FN_OR:   alu_ctrl_o = ALU_OR;
          FN_SLT:  alu_ctrl_o = ALU_SLT;
          default: funct_ok_o = 1'b0;
        endcase
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/mips_multicycle_ctrl.sv
// Multi-cycle control FSM: fetch/decode/execute/memory/writeback sequencing.
module mips_multicycle_ctrl
  import mips_ctrl_pkg::*;
#(
  parameter int unsigned RESET_HOLD = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  mips_multicycle_ctrl_if.master bus
);

  localparam logic [3:0] HOLD_LAST = 4'(RESET_HOLD - 1);

  state_e     state_q, state_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic       reg_dst_q, reg_dst_d;   // 1 = rd (R-type), 0 = rt (addi)
  alu_class_e alu_class;
  logic [3:0] alu_ctrl_w;
  logic       funct_ok_w;
  ctrl_out_t  out;

  mips_alu_decoder u_alu_dec (
    .alu_class_i (alu_class),
    .funct_i     (bus.funct),
    .alu_ctrl_o  (alu_ctrl_w),
    .funct_ok_o  (funct_ok_w)
  );

  // State, hold counter and writeback-destination latch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_HOLD;
      hold_cnt_q <= '0;
      reg_dst_q  <= 1'b1;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values.
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      reg_dst_q  <= reg_dst_d;
    end
  end

  // ALU request class; kept apart from the main decode to avoid a comb loop.
  always_comb begin
    alu_class = ALU_CLS_NONE;
    case (state_q)
      S_FETCH:               if (bus.mem_ready) alu_class = ALU_CLS_ADD;
      S_EXEC_R:              alu_class = ALU_CLS_FUNCT;
      S_EXEC_I, S_MEM_ADDR:  alu_class = ALU_CLS_ADD;
      S_BRANCH:              alu_class = ALU_CLS_SUB;
      default: ;
    endcase
  end

  // Next-state and output decode from the registered state.
  always_comb begin
    state_d    = state_q;
    hold_cnt_d = hold_cnt_q;
    reg_dst_d  = reg_dst_q;
    out        = '0;
    case (state_q)
      S_HOLD: begin
        if (hold_cnt_q == HOLD_LAST) state_d = S_FETCH;
        else                         hold_cnt_d = hold_cnt_q + 4'd1;
      end
      S_FETCH: begin
        out.mem_rd = 1'b1;
        if (bus.mem_ready) begin
          out.ir_write  = 1'b1;
          out.pc_en     = 1'b1;
          out.pc_src    = PC_SRC_INC;
          out.alu_src_b = ALU_B_ONE;
          out.alu_ctrl  = alu_ctrl_w;
          state_d       = S_DECODE;
        end
      end
      S_DECODE: begin
        case (bus.opcode)
          OP_RTYPE:     state_d = S_EXEC_R;
          OP_LW, OP_SW: state_d = S_MEM_ADDR;
          OP_ADDI:      state_d = S_EXEC_I;
          OP_BEQ:       state_d = S_BRANCH;
          OP_J:         state_d = S_JUMP;
          default:      state_d = S_ILLEGAL;
        endcase
      end
      S_EXEC_R: begin
        out.alu_src_a = 1'b1;
        out.alu_src_b = ALU_B_RT;
        out.alu_ctrl  = alu_ctrl_w;
        reg_dst_d     = 1'b1;
        state_d       = funct_ok_w ? S_WB_R : S_ILLEGAL;
      end
      S_EXEC_I, S_MEM_ADDR: begin
        out.alu_src_a = 1'b1;
        out.alu_src_b = ALU_B_IMM;
        out.alu_ctrl  = alu_ctrl_w;
        if (state_q == S_EXEC_I) begin
          reg_dst_d = 1'b0;
          state_d   = S_WB_R;
        end else begin
          state_d = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
        end
      end
      S_MEM_RD: begin
        out.mem_rd = 1'b1;
        out.iord   = 1'b1;
        if (bus.mem_ready) state_d = S_WB_MEM;
      end
      S_MEM_WR: begin
        out.mem_wr = 1'b1;
        out.iord   = 1'b1;
        if (bus.mem_ready) begin
          out.instr_done = 1'b1;
          state_d        = S_FETCH;
        end
      end
      S_WB_R: begin
        out.reg_write  = 1'b1;
        out.reg_dst    = reg_dst_q;
        out.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_WB_MEM: begin
        out.reg_write  = 1'b1;
        out.mem_to_reg = 1'b1;
        out.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_BRANCH: begin
        out.alu_src_a  = 1'b1;
        out.alu_src_b  = ALU_B_RT;
        out.alu_ctrl   = alu_ctrl_w;
        out.branch     = 1'b1;
        out.pc_src     = PC_SRC_BRANCH;
        out.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_JUMP: begin
        out.pc_en      = 1'b1;
        out.pc_src     = PC_SRC_JUMP;
        out.instr_done = 1'b1;
        state_d        = S_FETCH;
      end
      S_ILLEGAL: out.illegal = 1'b1;
      default:   state_d = S_ILLEGAL;
    endcase
  end

  assign bus.pc_en      = out.pc_en;
  assign bus.pc_src     = out.pc_src;
  assign bus.branch     = out.branch;
  assign bus.ir_write   = out.ir_write;
  assign bus.iord       = out.iord;
  assign bus.mem_rd     = out.mem_rd;
  assign bus.mem_wr     = out.mem_wr;
  assign bus.reg_write  = out.reg_write;
  assign bus.reg_dst    = out.reg_dst;
  assign bus.mem_to_reg = out.mem_to_reg;
  assign bus.alu_src_a  = out.alu_src_a;
  assign bus.alu_src_b  = out.alu_src_b;
  assign bus.alu_ctrl   = out.alu_ctrl;
  assign bus.instr_done = out.instr_done;
  assign bus.illegal    = out.illegal;

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Directed bench for the multi-cycle controller; outputs compared as one vector.
module tb_mips_multicycle_ctrl;

  // Field order: pc_en pc_src branch ir_write iord mem_rd mem_wr reg_write
  //              reg_dst mem_to_reg alu_src_a alu_src_b alu_ctrl instr_done illegal
  localparam logic [19:0] O_ZERO        = 20'b0_00_0_0_0_0_0_0_0_0_0_00_0000_0_0;
  localparam logic [19:0] O_FETCH_WAIT  = 20'b0_00_0_0_0_1_0_0_0_0_0_00_0000_0_0;
  localparam logic [19:0] O_FETCH       = 20'b1_00_0_1_0_1_0_0_0_0_0_01_0010_0_0;
  localparam logic [19:0] O_EXEC_ADD    = 20'b0_00_0_0_0_0_0_0_0_0_1_00_0010_0_0;
  localparam logic [19:0] O_EXEC_SUB    = 20'b0_00_0_0_0_0_0_0_0_0_1_00_0110_0_0;
  localparam logic [19:0] O_EXEC_AND    = 20'b0_00_0_0_0_0_0_0_0_0_1_00_0000_0_0;
  localparam logic [19:0] O_EXEC_OR     = 20'b0_00_0_0_0_0_0_0_0_0_1_00_0001_0_0;
  localparam logic [19:0] O_EXEC_SLT    = 20'b0_00_0_0_0_0_0_0_0_0_1_00_0111_0_0;
  localparam logic [19:0] O_EXEC_IMM    = 20'b0_00_0_0_0_0_0_0_0_0_1_10_0010_0_0;
  localparam logic [19:0] O_WB_R        = 20'b0_00_0_0_0_0_0_1_1_0_0_00_0000_1_0;
  localparam logic [19:0] O_WB_I        = 20'b0_00_0_0_0_0_0_1_0_0_0_00_0000_1_0;
  localparam logic [19:0] O_MEM_RD      = 20'b0_00_0_0_1_1_0_0_0_0_0_00_0000_0_0;
  localparam logic [19:0] O_WB_MEM      = 20'b0_00_0_0_0_0_0_1_0_1_0_00_0000_1_0;
  localparam logic [19:0] O_MEM_WR      = 20'b0_00_0_0_1_0_1_0_0_0_0_00_0000_0_0;
  localparam logic [19:0] O_MEM_WR_DONE = 20'b0_00_0_0_1_0_1_0_0_0_0_00_0000_1_0;
  localparam logic [19:0] O_BRANCH      = 20'b0_01_1_0_0_0_0_0_0_0_1_00_0110_1_0;
  localparam logic [19:0] O_JUMP        = 20'b1_10_0_0_0_0_0_0_0_0_0_00_0000_1_0;
  localparam logic [19:0] O_ILLEGAL     = 20'b0_00_0_0_0_0_0_0_0_0_0_00_0000_0_1;

  localparam logic [5:0] OP_R = 6'b000000, OP_LW = 6'b100011, OP_SW = 6'b101011;
  localparam logic [5:0] OP_ADDI = 6'b001000, OP_BEQ = 6'b000100, OP_J = 6'b000010;
  localparam logic [5:0] OP_BAD = 6'b111111;
  localparam logic [5:0] F_ADD = 6'b100000, F_SUB = 6'b100010, F_AND = 6'b100100;
  localparam logic [5:0] F_OR = 6'b100101, F_SLT = 6'b101010, F_BAD = 6'b000001;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;
  logic [19:0] obs;

  mips_multicycle_ctrl_if bus ();

  mips_multicycle_ctrl #(.RESET_HOLD(1)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  assign obs = {bus.pc_en, bus.pc_src, bus.branch, bus.ir_write, bus.iord,
                bus.mem_rd, bus.mem_wr, bus.reg_write, bus.reg_dst,
                bus.mem_to_reg, bus.alu_src_a, bus.alu_src_b, bus.alu_ctrl,
                bus.instr_done, bus.illegal};

  task automatic check(input string tag, input logic [19:0] o, input logic [19:0] e);
    n_cmp++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: observed %b expected %b", tag, o, e);
    end
  endtask

  // One cycle: drive inputs at the falling edge, compare 1 ns later.
  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic zf, input logic [19:0] e, input string tag);
    @(negedge clk);
    bus.opcode    = op;
    bus.funct     = fn;
    bus.mem_ready = rdy;
    bus.zero_flag = zf;
    #1 check(tag, obs, e);
  endtask

  task automatic release_reset();
    @(negedge clk);
    reset = 1'b0;
    #1 check("hold", obs, O_ZERO);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    bus.opcode = OP_R; bus.funct = F_ADD; bus.mem_ready = 1'b1; bus.zero_flag = 1'b0;
    #1 check("in_reset", obs, O_ZERO);

    // Reset then add: HOLD cycle 1, FETCH cycle 2, WB_R cycle 5.
    release_reset();
    step(OP_R, F_ADD, 1, 0, O_FETCH,    "add_fetch");
    step(OP_R, F_ADD, 1, 0, O_ZERO,     "add_decode");
    step(OP_R, F_ADD, 1, 0, O_EXEC_ADD, "add_exec");
    step(OP_R, F_ADD, 1, 0, O_WB_R,     "add_wb");

    // Other R-type functs.
    step(OP_R, F_SUB, 1, 0, O_FETCH,    "sub_fetch");
    step(OP_R, F_SUB, 1, 0, O_ZERO,     "sub_decode");
    step(OP_R, F_SUB, 1, 0, O_EXEC_SUB, "sub_exec");
    step(OP_R, F_SUB, 1, 0, O_WB_R,     "sub_wb");
    step(OP_R, F_AND, 1, 0, O_FETCH,    "and_fetch");
    step(OP_R, F_AND, 1, 0, O_ZERO,     "and_decode");
    step(OP_R, F_AND, 1, 0, O_EXEC_AND, "and_exec");
    step(OP_R, F_AND, 1, 0, O_WB_R,     "and_wb");
    step(OP_R, F_OR,  1, 0, O_FETCH,    "or_fetch");
    step(OP_R, F_OR,  1, 0, O_ZERO,     "or_decode");
    step(OP_R, F_OR,  1, 0, O_EXEC_OR,  "or_exec");
    step(OP_R, F_OR,  1, 0, O_WB_R,     "or_wb");
    step(OP_R, F_SLT, 1, 0, O_FETCH,    "slt_fetch");
    step(OP_R, F_SLT, 1, 0, O_ZERO,     "slt_decode");
    step(OP_R, F_SLT, 1, 0, O_EXEC_SLT, "slt_exec");
    step(OP_R, F_SLT, 1, 0, O_WB_R,     "slt_wb");

    // addi writes rt (reg_dst latch cleared in EXEC_I).
    step(OP_ADDI, F_BAD, 1, 0, O_FETCH,    "addi_fetch");
    step(OP_ADDI, F_BAD, 1, 0, O_ZERO,     "addi_decode");
    step(OP_ADDI, F_BAD, 1, 0, O_EXEC_IMM, "addi_exec");
    step(OP_ADDI, F_BAD, 1, 0, O_WB_I,     "addi_wb");

    // lw: 2 fetch waits, 3 read waits, retire on the 10th cycle.
    step(OP_LW, 6'd0, 0, 0, O_FETCH_WAIT, "lw_fetch_w1");
    step(OP_LW, 6'd0, 0, 0, O_FETCH_WAIT, "lw_fetch_w2");
    step(OP_LW, 6'd0, 1, 0, O_FETCH,      "lw_fetch");
    step(OP_LW, 6'd0, 0, 0, O_ZERO,       "lw_decode");
    step(OP_LW, 6'd0, 1, 0, O_EXEC_IMM,   "lw_addr");
    step(OP_LW, 6'd0, 0, 0, O_MEM_RD,     "lw_rd_w1");
    step(OP_LW, 6'd0, 0, 0, O_MEM_RD,     "lw_rd_w2");
    step(OP_LW, 6'd0, 0, 0, O_MEM_RD,     "lw_rd_w3");
    step(OP_LW, 6'd0, 1, 0, O_MEM_RD,     "lw_rd");
    step(OP_LW, 6'd0, 1, 0, O_WB_MEM,     "lw_wb");

    // sw with one write wait.
    step(OP_SW, 6'd0, 1, 0, O_FETCH,       "sw_fetch");
    step(OP_SW, 6'd0, 1, 0, O_ZERO,        "sw_decode");
    step(OP_SW, 6'd0, 1, 0, O_EXEC_IMM,    "sw_addr");
    step(OP_SW, 6'd0, 0, 0, O_MEM_WR,      "sw_wr_w1");
    step(OP_SW, 6'd0, 1, 0, O_MEM_WR_DONE, "sw_wr");

    // beq taken and not taken: identical controller outputs, 3 cycles each.
    step(OP_BEQ, 6'd0, 1, 1, O_FETCH,  "beq1_fetch");
    step(OP_BEQ, 6'd0, 0, 1, O_ZERO,   "beq1_decode");
    step(OP_BEQ, 6'd0, 0, 1, O_BRANCH, "beq1_branch");
    step(OP_BEQ, 6'd0, 1, 0, O_FETCH,  "beq0_fetch");
    step(OP_BEQ, 6'd0, 1, 0, O_ZERO,   "beq0_decode");
    step(OP_BEQ, 6'd0, 1, 0, O_BRANCH, "beq0_branch");

    // j.
    step(OP_J, 6'd0, 1, 0, O_FETCH, "j_fetch");
    step(OP_J, 6'd0, 1, 0, O_ZERO,  "j_decode");
    step(OP_J, 6'd0, 1, 0, O_JUMP,  "j_jump");

    // Illegal opcode: sticky, no further fetches.
    step(OP_BAD, 6'd0, 1, 0, O_FETCH,   "bad_op_fetch");
    step(OP_BAD, 6'd0, 1, 0, O_ZERO,    "bad_op_decode");
    step(OP_BAD, 6'd0, 1, 0, O_ILLEGAL, "bad_op_ill1");
    step(OP_R,   F_ADD, 1, 0, O_ILLEGAL, "bad_op_ill2");
    step(OP_R,   F_ADD, 0, 0, O_ILLEGAL, "bad_op_ill3");
    @(negedge clk);
    reset = 1'b1;
    #1 check("bad_op_reset", obs, O_ZERO);
    release_reset();
    step(OP_R, F_BAD, 1, 0, O_FETCH, "restart_fetch");

    // Illegal funct: no register write, then ILLEGAL.
    step(OP_R, F_BAD, 1, 0, O_ZERO, "bad_fn_decode");
    step(OP_R, F_BAD, 1, 0, O_EXEC_AND, "bad_fn_exec");
    check("bad_fn_no_wr", {19'd0, bus.reg_write}, 20'd0);
    step(OP_R, F_BAD, 1, 0, O_ILLEGAL, "bad_fn_ill1");
    step(OP_R, F_BAD, 1, 0, O_ILLEGAL, "bad_fn_ill2");
    @(negedge clk);
    reset = 1'b1;
    #1 check("bad_fn_reset", obs, O_ZERO);
    release_reset();

    // Reset during a MEM_WR wait drops mem_wr in the same cycle.
    step(OP_SW, 6'd0, 1, 0, O_FETCH,    "rst_sw_fetch");
    step(OP_SW, 6'd0, 1, 0, O_ZERO,     "rst_sw_decode");
    step(OP_SW, 6'd0, 1, 0, O_EXEC_IMM, "rst_sw_addr");
    step(OP_SW, 6'd0, 0, 0, O_MEM_WR,   "rst_sw_wait");
    #2 reset = 1'b1;
    #1 check("rst_mid", obs, O_ZERO);
    step(OP_SW, 6'd0, 1, 0, O_ZERO, "rst_held");
    release_reset();
    step(OP_J, 6'd0, 1, 0, O_FETCH, "rst_refetch");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle control FSM for the non-pipelined MIPS core. It sequences the shared datapath (PC update logic, instruction register, unified memory port, register file, ALU) through fetch, decode, execute, memory and writeback steps, one instruction at a time. It accepts wait states on the memory port and flags unsupported opcodes.

## Interface
Parameters:
- `RESET_HOLD`, default 1: idle cycles after reset release before the first fetch (range 1..15).

Ports:
- `clk`  in  1  system clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `opcode`  in  6  IR[31:26]; valid from DECODE onward.
- `funct`  in  6  IR[5:0].
- `zero_flag`  in  1  ALU zero result, combinational from the datapath.
- `mem_ready`  in  1  memory completes the current `mem_rd`/`mem_wr` this cycle.
- `pc_en`  out  1  PC register load enable.
- `pc_src`  out  2  PC source: 0 = pc+1, 1 = branch target, 2 = jump target.
- `branch`  out  1  branch qualifier; PC loads the target only if `zero_flag` is also high.
- `ir_write`  out  1  instruction register load.
- `iord`  out  1  memory address select: 0 = PC, 1 = ALU result register.
- `mem_rd`, `mem_wr`  out  1 each  memory request strobes.
- `reg_write`, `reg_dst`, `mem_to_reg`  out  1 each  register file write enable, rd/rt select, writeback source.
- `alu_src_a`  out  1  0 = PC, 1 = rs.
- `alu_src_b`  out  2  0 = rt, 1 = constant 1, 2 = sign-extended imm.
- `alu_ctrl`  out  4  ALU operation code.
- `instr_done`  out  1  one-cycle pulse on the final cycle of each retired instruction.
- `illegal`  out  1  sticky unsupported-instruction flag.

## Operation
- States: HOLD, FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WR, WB_R, WB_MEM, BRANCH, JUMP, ILLEGAL.
- HOLD: all outputs 0. Counts `RESET_HOLD` cycles, then goes to FETCH.
- FETCH: `mem_rd`=1, `iord`=0. Waits while `mem_ready`=0. On ready: `ir_write`=1, `pc_en`=1, `pc_src`=0, `alu_src_a`=0, `alu_src_b`=1, `alu_ctrl`=ADD. Then goes to DECODE.
- DECODE: decodes `opcode`.
  - 000000 → EXEC_R.
  - 100011 (lw) / 101011 (sw) → MEM_ADDR.
  - 001000 (addi) → EXEC_I.
  - 000100 (beq) → BRANCH.
  - 000010 (j) → JUMP.
  - Any other opcode → ILLEGAL.
- EXEC_R: `alu_src_a`=1, `alu_src_b`=0, `alu_ctrl` taken from funct.
  - funct 100000 ADD=0010, 100010 SUB=0110, 100100 AND=0000, 100101 OR=0001, 101010 SLT=0111.
  - Any other funct → ILLEGAL in the next cycle; the register file is not written.
  - Otherwise → WB_R.
- WB_R: `reg_write`=1, `reg_dst`=1, `mem_to_reg`=0, `instr_done`=1 → FETCH.
- EXEC_I: `alu_src_a`=1, `alu_src_b`=2, ADD → WB_I.
  - WB_I uses WB_R timing with `reg_dst`=0. It is encoded as WB_R with a registered `reg_dst` latch, set in EXEC_I.
- MEM_ADDR: `alu_src_a`=1, `alu_src_b`=2, ADD → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: `mem_rd`=1, `iord`=1. Waits for `mem_ready`, then → WB_MEM.
- WB_MEM: `reg_write`=1, `reg_dst`=0, `mem_to_reg`=1, `instr_done`=1 → FETCH.
- MEM_WR: `mem_wr`=1, `iord`=1. On `mem_ready`: `instr_done`=1 → FETCH.
- BRANCH: `alu_src_a`=1, `alu_src_b`=0, SUB, `branch`=1, `pc_src`=1, `instr_done`=1 → FETCH. The controller does not itself gate on `zero_flag`.
- JUMP: `pc_en`=1, `pc_src`=2, `instr_done`=1 → FETCH.
- ILLEGAL: all strobes 0, `illegal`=1. Remains there until `reset`.
- Outputs not listed for a state are 0. Outputs are decoded from the registered state plus the `mem_ready`/funct qualifiers named above.

## Timing
- Reset (asynchronous assert): state = HOLD and every output 0 immediately. `illegal` clears. The hold counter clears.
- Reset asserted mid-instruction aborts the instruction with no further strobes. A pending memory request drops in the same cycle.
- Latency with zero wait states (FETCH through the retire cycle, inclusive):
  - R-type and addi: 4 cycles.
  - lw: 5 cycles.
  - sw: 4 cycles.
  - beq and j: 3 cycles.
- Each `mem_ready`=0 cycle in FETCH, MEM_RD or MEM_WR adds exactly one cycle.
- `mem_rd`/`mem_wr` stay high and stable until the cycle in which `mem_ready`=1.
- `mem_ready` arriving outside a request state is ignored.
- `instr_done` pulses once per retired instruction. It never pulses for an instruction that enters ILLEGAL.

## Structure
- Shared package `mips_ctrl_pkg` holds:
  - the state enum;
  - the opcode and funct constants;
  - the `alu_ctrl` codes;
  - the `pc_src`/`alu_src_b` encodings.
  The datapath imports the same encodings.
- Sub-module `mips_alu_decoder`: combinational, maps (state class, funct) to `alu_ctrl` plus a `funct_ok` flag.

## Test plan
- **Reset then add:** reset released with `RESET_HOLD`=1, memory always ready, IR = add (opcode 0, funct 100000). Required: FETCH at cycle 2, `reg_write`=1 with `reg_dst`=1 at cycle 5, `instr_done` at cycle 5.
- **lw with wait states:** `mem_ready` low for 2 cycles during FETCH and 3 cycles during MEM_RD. Required: `mem_rd` held throughout both waits, `instr_done` 10 cycles after FETCH entry.
- **beq:** beq with `zero_flag`=1, then beq with `zero_flag`=0. Required: `branch`=1 and `pc_src`=1 in the third cycle of both, retire in 3 cycles each.
- **Illegal opcode:** opcode 111111. Required: ILLEGAL after DECODE, `illegal`=1, no further `mem_rd`. Reset clears `illegal` and the core restarts in HOLD.
- **Illegal funct:** R-type with funct 000001. Required: no `reg_write`, `illegal`=1.
- **Reset mid-operation:** `reset` asserted during MEM_WR wait. Required: `mem_wr` drops in the same cycle and all outputs are 0.
